sccb_arbiter: RTL and testbench

- Two-port arbiter that shares the single SCCB write interface (addr/data/start/ready) between port 0 and port 1.
  - Port 0: the ROM-driven camera configuration sequencer.
  - Port 1: the runtime tuning source (exposure/gain writes from user controls).
- Sits between the requesters and the SCCB master.
- Serialises commands, enforces config-phase exclusivity via a lock input, round-robins otherwise, and supervises the downstream ready handshake with timeouts.

---
 rtl/sccb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sccb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_arbiter.sv
// sccb_arbiter: shares one SCCB write channel between the ROM config
// sequencer (port 0) and the runtime tuning source (port 1).
// Commands are serialised, port 0 is exclusive while cfg_lock is high,
// otherwise ports alternate on contention. The downstream ready handshake
// is supervised: ready must drop shortly after start and must return
// within the done timeout, or a sticky error is raised.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no command in flight; grant when ready high and a port eligible
// WAIT_DROP | start issued; waiting for ready to deassert (DROP_CYCLES max)
// WAIT_DONE | SCCB master busy; waiting for ready to return (timeout max)

module sccb_arbiter #(
    parameter int unsigned CLK_FREQ        = 25000000,
    parameter int unsigned DROP_CYCLES     = 4,
    parameter int unsigned DONE_TIMEOUT_US = 2000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0,
    input  logic [7:0]  addr0,
    input  logic [7:0]  data0,
    output logic        ack0,

    input  logic        req1,
    input  logic [7:0]  addr1,
    input  logic [7:0]  data1,
    output logic        ack1,

    input  logic        cfg_lock,
    input  logic        err_clr,

    input  logic        SCCB_interface_ready,
    output logic [7:0]  SCCB_interface_addr,
    output logic [7:0]  SCCB_interface_data,
    output logic        SCCB_interface_start,

    output logic        busy,
    output logic        grant_id,
    output logic        err_drop,
    output logic        err_timeout,
    output logic [15:0] txn_count
);

    localparam int unsigned TIMEOUT_CYCLES = (CLK_FREQ / 1000000) * DONE_TIMEOUT_US;
    localparam int unsigned TIMER_MAX      = (TIMEOUT_CYCLES > DROP_CYCLES) ? TIMEOUT_CYCLES
                                                                            : DROP_CYCLES;
    localparam int unsigned TW             = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    // The timer counts down to zero; loading N-1 gives an N-cycle window.
    localparam logic [TW-1:0] DROP_LOAD = TW'(DROP_CYCLES - 1);
    localparam logic [TW-1:0] DONE_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DROP = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic           last;
    logic           elig0;
    logic           elig1;
    logic           grant_port;

    // Eligibility and round-robin pick; the lock only masks port 1.
    always_comb begin
        elig0      = req0;
        elig1      = req1 && !cfg_lock;
        grant_port = 1'b0;
        if (elig0 && elig1) begin
            grant_port = ~last;
        end else begin
            grant_port = elig1;
        end
    end

    // Arbitration FSM with registered outputs and handshake supervision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE;
            timer                <= '0;
            last                 <= 1'b1;
            ack0                 <= 1'b0;
            ack1                 <= 1'b0;
            SCCB_interface_addr  <= '0;
            SCCB_interface_data  <= '0;
            SCCB_interface_start <= 1'b0;
            busy                 <= 1'b0;
            grant_id             <= 1'b0;
            err_drop             <= 1'b0;
            err_timeout          <= 1'b0;
            txn_count            <= '0;
        end else begin
            // A set later in this block overrides a simultaneous clear.
            if (err_clr) begin
                err_drop    <= 1'b0;
                err_timeout <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (SCCB_interface_ready && (elig0 || elig1)) begin
                        SCCB_interface_addr  <= grant_port ? addr1 : addr0;
                        SCCB_interface_data  <= grant_port ? data1 : data0;
                        SCCB_interface_start <= 1'b1;
                        ack0                 <= ~grant_port;
                        ack1                 <= grant_port;
                        grant_id             <= grant_port;
                        last                 <= grant_port;
                        timer                <= DROP_LOAD;
                        busy                 <= 1'b1;
                        state                <= WAIT_DROP;
                    end
                end

                WAIT_DROP: begin
                    SCCB_interface_start <= 1'b0;
                    ack0                 <= 1'b0;
                    ack1                 <= 1'b0;
                    if (!SCCB_interface_ready) begin
                        timer <= DONE_LOAD;
                        state <= WAIT_DONE;
                    end else if (timer == '0) begin
                        err_drop <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                WAIT_DONE: begin
                    if (SCCB_interface_ready) begin
                        if (txn_count != 16'hFFFF) begin
                            txn_count <= txn_count + 16'd1;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (timer == '0) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_arbiter.sv
// tb_sccb_arbiter: directed scenarios with literal expectations followed by
// a randomized phase, all checked every cycle against a transaction-level
// model of the arbiter.

module tb_sccb_arbiter;

    localparam int DROP_N = 4;
    localparam int TMO_N  = 25;  // 25 MHz * 1 us

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [7:0]  addr0, data0, addr1, data1;
    logic        ack0, ack1;
    logic        cfg_lock, err_clr;
    logic        sccb_ready;
    logic [7:0]  sccb_addr, sccb_data;
    logic        sccb_start;
    logic        busy, grant_id, err_drop, err_timeout;
    logic [15:0] txn_count;

    sccb_arbiter #(
        .CLK_FREQ        (25000000),
        .DROP_CYCLES     (DROP_N),
        .DONE_TIMEOUT_US (1)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req0                 (req0),
        .addr0                (addr0),
        .data0                (data0),
        .ack0                 (ack0),
        .req1                 (req1),
        .addr1                (addr1),
        .data1                (data1),
        .ack1                 (ack1),
        .cfg_lock             (cfg_lock),
        .err_clr              (err_clr),
        .SCCB_interface_ready (sccb_ready),
        .SCCB_interface_addr  (sccb_addr),
        .SCCB_interface_data  (sccb_data),
        .SCCB_interface_start (sccb_start),
        .busy                 (busy),
        .grant_id             (grant_id),
        .err_drop             (err_drop),
        .err_timeout          (err_timeout),
        .txn_count            (txn_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_in_txn, m_dropped, m_last;
    logic        m_start, m_ack0, m_ack1, m_gid, m_edrop, m_etmo;
    logic [7:0]  m_addr, m_data;
    logic [15:0] m_cnt;
    int          m_k;
    logic        m_sd, m_st, m_e0, m_e1, m_g;

    // Transaction-level view: a transaction lives from grant until ready
    // returns or a supervision window (counted in edges) expires.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_in_txn = 0; m_dropped = 0; m_k = 0; m_last = 1;
            m_start = 0; m_ack0 = 0; m_ack1 = 0; m_gid = 0;
            m_addr = 0; m_data = 0; m_edrop = 0; m_etmo = 0; m_cnt = 0;
        end else begin
            m_sd = 0; m_st = 0;
            if (!m_in_txn) begin
                m_e0 = req0;
                m_e1 = req1 && !cfg_lock;
                if (sccb_ready && (m_e0 || m_e1)) begin
                    m_g = (m_e0 && m_e1) ? !m_last : m_e1;
                    m_addr = m_g ? addr1 : addr0;
                    m_data = m_g ? data1 : data0;
                    m_start = 1; m_ack0 = !m_g; m_ack1 = m_g;
                    m_gid = m_g; m_last = m_g;
                    m_in_txn = 1; m_dropped = 0; m_k = 0;
                end
            end else begin
                m_start = 0; m_ack0 = 0; m_ack1 = 0;
                m_k = m_k + 1;
                if (!m_dropped) begin
                    if (!sccb_ready) begin
                        m_dropped = 1; m_k = 0;
                    end else if (m_k == DROP_N) begin
                        m_sd = 1; m_in_txn = 0;
                    end
                end else begin
                    if (sccb_ready) begin
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
                        m_in_txn = 0;
                    end else if (m_k == TMO_N) begin
                        m_st = 1; m_in_txn = 0;
                    end
                end
            end
            m_edrop = m_sd || (m_edrop && !err_clr);
            m_etmo  = m_st || (m_etmo && !err_clr);
        end
    end

    // ---------------- bench state ----------------
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 0;
    int resp_mode = 0;   // 0 manual ready, 1 random downstream, 2 fixed downstream
    bit req_auto = 0;
    int rs_act = 0, rs_wait = 0, rs_low = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock step: compare DUT against model, then update stimulus.
    task automatic tick();
        logic [38:0] dv, mv;
        int r;
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            dv = {sccb_start, ack0, ack1, busy, grant_id, err_drop, err_timeout,
                  sccb_addr, sccb_data, txn_count};
            mv = {m_start, m_ack0, m_ack1, m_in_txn, m_gid, m_edrop, m_etmo,
                  m_addr, m_data, m_cnt};
            check("model_cmp", dv, mv);
            check("ack_exclusive", ack0 & ack1, 1'b0);
        end
        if (resp_mode != 0) begin
            if (m_start) begin
                rs_act = 1;
                if (resp_mode == 2) begin
                    rs_wait = 0; rs_low = 3;
                end else begin
                    r = $urandom_range(0, 9);
                    rs_wait = (r < 8) ? (r % 3) : (r - 4);
                    rs_low  = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(1, 20);
                end
            end
            if (rs_act != 0) begin
                if (rs_wait > 0) begin
                    rs_wait--; sccb_ready = 1;
                end else if (rs_low > 0) begin
                    sccb_ready = 0; rs_low--;
                end else begin
                    sccb_ready = 1; rs_act = 0;
                end
            end else if (resp_mode == 1) begin
                sccb_ready = ($urandom_range(0, 15) != 0);
            end else begin
                sccb_ready = 1;
            end
        end
        if (req_auto) begin
            if (m_ack0) begin
                if ($urandom_range(0, 1) == 0) req0 = 0;
                else begin addr0 = 8'($urandom); data0 = 8'($urandom); end
            end else if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1; addr0 = 8'($urandom); data0 = 8'($urandom);
            end
            if (m_ack1) begin
                if ($urandom_range(0, 1) == 0) req1 = 0;
                else begin addr1 = 8'($urandom); data1 = 8'($urandom); end
            end else if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1; addr1 = 8'($urandom); data1 = 8'($urandom);
            end
            if ($urandom_range(0, 63) == 0) cfg_lock = !cfg_lock;
            err_clr = ($urandom_range(0, 31) == 0);
            rst_n   = ($urandom_range(0, 499) != 0);
        end
    endtask

    task automatic wait_ack(input int port, input int max_cyc);
        bit seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if ((port == 0) ? ack0 : ack1) seen = 1;
        end
        check($sformatf("wait_ack%0d", port), seen, 1'b1);
    endtask

    task automatic wait_idle(input int max_cyc);
        bit idle = 0;
        for (int i = 0; i < max_cyc && !idle; i++) begin
            tick();
            if (!busy) idle = 1;
        end
        check("wait_idle", idle, 1'b1);
    endtask

    task automatic run_grants(input int n, input logic [7:0] exp_ports, input int unlock_after);
        int got_n = 0;
        int last_start = -1;
        for (int t = 0; t < 400 && got_n < n; t++) begin
            tick();
            if (sccb_start) begin
                if (last_start >= 0) check("start_gap_ge2", (cyc - last_start) >= 2, 1'b1);
                last_start = cyc;
            end
            if (ack0 || ack1) begin
                check($sformatf("grant_order_%0d", got_n), ack1, exp_ports[got_n]);
                if (ack1) begin addr1 = addr1 + 8'd1; data1 = 8'($urandom); end
                else      begin addr0 = addr0 + 8'd1; data0 = 8'($urandom); end
                got_n++;
                if (got_n == unlock_after) cfg_lock = 0;
            end
        end
        check("grant_count", got_n, n);
        req0 = 0; req1 = 0;
    endtask

    int busy_cyc;
    int acks_seen;
    int starts_seen;

    initial begin
        rst_n = 0; req0 = 0; req1 = 0; addr0 = 0; data0 = 0; addr1 = 0; data1 = 0;
        cfg_lock = 0; err_clr = 0; sccb_ready = 1;

        // Reset state
        tick(); tick();
        chk_en = 1;
        check("reset_outputs",
              {sccb_start, ack0, ack1, busy, grant_id, err_drop, err_timeout, sccb_addr, sccb_data, txn_count},
              39'd0);
        rst_n = 1;
        tick();

        // Single port 0 write, ready low for 10 edges
        req0 = 1; addr0 = 8'd12; data0 = 8'd80;
        tick();
        check("p0_start", sccb_start, 1'b1);
        check("p0_ack0", {ack0, ack1}, 2'b10);
        check("p0_addr", sccb_addr, 8'd12);
        check("p0_data", sccb_data, 8'd80);
        req0 = 0; sccb_ready = 0; busy_cyc = 1;
        repeat (10) begin tick(); if (busy) busy_cyc++; end
        sccb_ready = 1;
        tick();
        check("p0_busy_len", busy_cyc, 11);
        check("p0_idle", busy, 1'b0);
        check("p0_txn", txn_count, 16'd1);

        // Contention without lock, after reset so port 0 wins first
        rst_n = 0; tick(); rst_n = 1;
        resp_mode = 2; cfg_lock = 0;
        req0 = 1; addr0 = 8'h20; data0 = 8'hA0;
        req1 = 1; addr1 = 8'h40; data1 = 8'hB0;
        run_grants(4, 8'b0000_1010, 0);
        wait_idle(50);

        // Lock: only port 0 until released, then port 1
        cfg_lock = 1; req0 = 1; req1 = 1;
        run_grants(4, 8'b0000_1000, 3);
        wait_idle(50);
        check("txn_after_lock", txn_count, 16'd8);

        // Drop fault: ready stays high after start
        resp_mode = 0; sccb_ready = 1;
        req0 = 1; addr0 = 8'h55; data0 = 8'h66;
        wait_ack(0, 5);
        req0 = 0;
        repeat (3) tick();
        check("drop_pending", {err_drop, busy}, 2'b01);
        tick();
        check("drop_err", {err_drop, busy}, 2'b10);
        check("drop_txn_same", txn_count, 16'd8);
        err_clr = 1; tick(); err_clr = 0;
        check("drop_cleared", err_drop, 1'b0);

        // Done timeout: ready held low
        req1 = 1; addr1 = 8'h77; data1 = 8'h88;
        wait_ack(1, 5);
        req1 = 0; sccb_ready = 0;
        repeat (25) tick();
        check("tmo_pending", {err_timeout, busy}, 2'b01);
        tick();
        check("tmo_err", {err_timeout, busy}, 2'b10);
        req0 = 1; addr0 = 8'h99; data0 = 8'h11;
        acks_seen = 0; starts_seen = 0;
        repeat (10) begin tick(); acks_seen += ack0 + ack1; starts_seen += sccb_start; end
        check("no_grant_ready_low", acks_seen + starts_seen, 0);
        sccb_ready = 1;
        wait_ack(0, 5);
        check("tmo_regrant_addr", sccb_addr, 8'h99);
        req0 = 0; sccb_ready = 0; tick(); tick(); sccb_ready = 1;
        wait_idle(20);
        check("tmo_txn", txn_count, 16'd9);

        // Reset during WAIT_DONE
        req0 = 1; addr0 = 8'h33; data0 = 8'h44;
        wait_ack(0, 5);
        req0 = 0; sccb_ready = 0;
        repeat (5) tick();
        rst_n = 0; tick();
        check("midrst_outputs",
              {sccb_start, ack0, ack1, busy, grant_id, err_drop, err_timeout, sccb_addr, sccb_data, txn_count},
              39'd0);
        rst_n = 1; req1 = 1; addr1 = 8'hC3; data1 = 8'hD4;
        acks_seen = 0;
        repeat (5) begin tick(); acks_seen += ack0 + ack1; end
        check("midrst_wait_ready", acks_seen, 0);
        sccb_ready = 1;
        wait_ack(1, 5);
        check("midrst_gid", grant_id, 1'b1);
        req1 = 0; sccb_ready = 0; tick(); sccb_ready = 1;
        wait_idle(20);
        check("midrst_txn", txn_count, 16'd1);

        // Randomized traffic against the model
        resp_mode = 1; req_auto = 1;
        repeat (4000) tick();
        req_auto = 0; resp_mode = 0; sccb_ready = 1; rst_n = 1;
        req0 = 0; req1 = 0; cfg_lock = 0; err_clr = 0;
        wait_idle(60);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
